// File: rtl/xres_reset_pkg.sv
// Purpose : shared types and legal parameter bounds for the XRES reset sequencer.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package xres_reset_pkg;

  // Sequencer states; SWRST is only reachable when XRES_SW_RESET_EN is defined.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SWRST   = 2'd3
  } xres_state_e;

  localparam int XRES_MAX_DOMAINS = 8;
  localparam int XRES_MIN_FILT    = 2;

endpackage

// File: rtl/xres_glitch_filter.sv
// Purpose : 2-flop synchroniser plus stability counter for the XRES pad level.
// Latency : sync 2 edges; a new level is accepted FILT_LEN edges after it reaches xres_sync (bypass: 1 edge).
// Backpressure : none; the level is sampled every cycle.
// Ports: clk/rst (sync, active-high), xres_n (async pad level), filt_bypass (skip counter),
//        xres_filt (registered, filtered level).
module xres_glitch_filter
  import xres_reset_pkg::*;
#(
  parameter int FILT_LEN = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic xres_n,
  input  logic filt_bypass,
  output logic xres_filt
);

  localparam logic [CNT_W-1:0] FCNT_LAST = CNT_W'(FILT_LEN - 1);

  logic             sync_q1;
  logic             xres_sync;
  logic [CNT_W-1:0] fcnt;

  if (FILT_LEN < XRES_MIN_FILT) begin : g_bad_filt_len
    $error("xres_glitch_filter: FILT_LEN below minimum");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b0;
      xres_sync <= 1'b0;
      xres_filt <= 1'b0;
      fcnt      <= '0;
    end else begin
      sync_q1   <= xres_n;
      xres_sync <= sync_q1;
      // Bypass is evaluated every cycle, so flipping it mid-count drops the count.
      if (filt_bypass) begin
        xres_filt <= xres_sync;
        fcnt      <= '0;
      end else if (xres_sync == xres_filt) begin
        fcnt <= '0;
      end else if (fcnt == FCNT_LAST) begin
        xres_filt <= xres_sync;
        fcnt      <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/xres_reset_sequencer.sv
// Purpose : filters the XRES pad level and releases NUM_DOMAINS resets in staggered order.
// Latency : domain k released 3+FILT_LEN+(k+1)*STAGE_GAP edges after xres_n_i is first sampled high.
// Backpressure : none; sw_rst_req_i is a level, acknowledged by a one-cycle sw_rst_ack_o pulse.
// Ports: wb_clk_i/wb_rst_i (sync, active-high), xres_n_i, filt_bypass_i, rst_n_o[NUM_DOMAINS],
//        rst_done_o, xres_filt_o; sw_rst_req_i/sw_rst_ack_o only with macro XRES_SW_RESET_EN.
module xres_reset_sequencer
  import xres_reset_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int FILT_LEN    = 16,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = $clog2((FILT_LEN > STAGE_GAP) ? FILT_LEN : STAGE_GAP) + 1
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   xres_n_i,
  input  logic                   filt_bypass_i,
`ifdef XRES_SW_RESET_EN
  input  logic                   sw_rst_req_i,
  output logic                   sw_rst_ack_o,
`endif
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   rst_done_o,
  output logic                   xres_filt_o
);

  localparam int IDX_W = $clog2(NUM_DOMAINS);
  localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST = CNT_W'(STAGE_GAP - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE  = NUM_DOMAINS'(1);

  if (NUM_DOMAINS < 2 || NUM_DOMAINS > XRES_MAX_DOMAINS) begin : g_bad_domains
    $error("xres_reset_sequencer: NUM_DOMAINS out of range");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("xres_reset_sequencer: STAGE_GAP must be at least 1");
  end

  xres_state_e      state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] gap;
  logic             xres_filt;
`ifdef XRES_SW_RESET_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FILT_LEN - 1);
  logic             sw_pend;   // set while a software reset awaits its ack
`endif

  xres_glitch_filter #(
    .FILT_LEN (FILT_LEN),
    .CNT_W    (CNT_W)
  ) u_filter (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .xres_n      (xres_n_i),
    .filt_bypass (filt_bypass_i),
    .xres_filt   (xres_filt)
  );

  // Already a flop inside the filter.
  assign xres_filt_o = xres_filt;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= HOLD;
      idx        <= '0;
      gap        <= '0;
      rst_n_o    <= '0;
      rst_done_o <= 1'b0;
`ifdef XRES_SW_RESET_EN
      sw_pend      <= 1'b0;
      sw_rst_ack_o <= 1'b0;
`endif
    end else begin
`ifdef XRES_SW_RESET_EN
      sw_rst_ack_o <= 1'b0;
`endif
      if (!xres_filt) begin
        // Pad reset wins over everything, including an in-flight software reset.
        state      <= HOLD;
        idx        <= '0;
        gap        <= '0;
        rst_n_o    <= '0;
        rst_done_o <= 1'b0;
`ifdef XRES_SW_RESET_EN
        sw_pend    <= 1'b0;
`endif
      end else begin
        case (state)
          HOLD: begin
            state <= RELEASE;
            idx   <= '0;
            gap   <= '0;
          end
          RELEASE: begin
            if (gap == GAP_LAST) begin
              rst_n_o <= rst_n_o | (DOM_ONE << idx);
              gap     <= '0;
              if (idx == IDX_LAST) begin
                state      <= RUN;
                rst_done_o <= 1'b1;
`ifdef XRES_SW_RESET_EN
                sw_rst_ack_o <= sw_pend;
                sw_pend      <= 1'b0;
`endif
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              gap <= gap + 1'b1;
            end
          end
          RUN: begin
`ifdef XRES_SW_RESET_EN
            if (sw_rst_req_i) begin
              state      <= SWRST;
              rst_n_o    <= DOM_ONE;   // domain 0 stays out of reset
              rst_done_o <= 1'b0;
              gap        <= '0;
              sw_pend    <= 1'b1;
            end
`endif
          end
`ifdef XRES_SW_RESET_EN
          SWRST: begin
            // gap doubles as the hold timer; the request level is not looked at here.
            if (gap == HOLD_LAST) begin
              state <= RELEASE;
              idx   <= IDX_W'(1);
              gap   <= '0;
            end else begin
              gap <= gap + 1'b1;
            end
          end
`endif
          default: begin
            state <= HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Purpose : directed self-checking bench for xres_reset_sequencer (3 domains, FILT_LEN 4, STAGE_GAP 2).
// Latency : expected values are hand-derived edge counts from the first sampled input change.
// Backpressure : n/a; sw tests only built when XRES_SW_RESET_EN is defined.
module tb_xres_reset_sequencer;

  logic       clk = 1'b0;
  logic       wb_rst;
  logic       xres_n;
  logic       bypass;
  logic [2:0] rst_n;
  logic       done;
  logic       filt;
`ifdef XRES_SW_RESET_EN
  logic       sw_req;
  logic       sw_ack;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  xres_reset_sequencer #(
    .NUM_DOMAINS (3),
    .FILT_LEN    (4),
    .STAGE_GAP   (2)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst),
    .xres_n_i      (xres_n),
    .filt_bypass_i (bypass),
`ifdef XRES_SW_RESET_EN
    .sw_rst_req_i  (sw_req),
    .sw_rst_ack_o  (sw_ack),
`endif
    .rst_n_o       (rst_n),
    .rst_done_o    (done),
    .xres_filt_o   (filt)
  );

  // Advance one active edge and settle; inputs set after this land on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    xres_n = 1'b0;
    bypass = 1'b0;
`ifdef XRES_SW_RESET_EN
    sw_req = 1'b0;
`endif
    repeat (3) tick();
    total_cnt++;
    if (rst_n !== 3'b000) $display("FAIL reset_rst_n: got %b want 000", rst_n);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
    else pass_cnt++;
`ifdef XRES_SW_RESET_EN
    total_cnt++;
    if (sw_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", sw_ack);
    else pass_cnt++;
`endif
    // A high pad level must not leak through while reset is held.
    xres_n = 1'b1;
    repeat (4) tick();
    total_cnt++;
    if (filt !== 1'b0 || rst_n !== 3'b000)
      $display("FAIL reset_hold: got filt=%b rst_n=%b want filt=0 rst_n=000", filt, rst_n);
    else pass_cnt++;
  endtask

  task automatic test_power_up();
    logic [2:0] exp_rst;
    wb_rst = 1'b0;   // next edge is edge 1, xres_n already high
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp_rst = (e >= 13) ? 3'b111 : (e >= 11) ? 3'b011 : (e >= 9) ? 3'b001 : 3'b000;
      total_cnt++;
      if (rst_n !== exp_rst || done !== (e >= 13) || filt !== (e >= 6))
        $display("FAIL power_up edge %0d: got rst_n=%b done=%b filt=%b want rst_n=%b done=%b filt=%b",
                 e, rst_n, done, filt, exp_rst, (e >= 13), (e >= 6));
      else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    int waited;
    // Three low samples: rejected by the filter.
    xres_n = 1'b0;
    repeat (3) tick();
    xres_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      total_cnt++;
      if (rst_n !== 3'b111 || done !== 1'b1 || filt !== 1'b1)
        $display("FAIL glitch3 cycle %0d: got rst_n=%b done=%b filt=%b want 111 1 1", k, rst_n, done, filt);
      else pass_cnt++;
    end
    // Four low samples: accepted; tick k lands on edge E+k-1.
    xres_n = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 4) xres_n = 1'b1;
      if (k == 5 || k == 6) begin
        total_cnt++;
        if (filt !== (k == 5)) $display("FAIL glitch4_filt tick %0d: got %b want %b", k, filt, (k == 5));
        else pass_cnt++;
      end
      total_cnt++;
      if (k <= 6 && rst_n !== 3'b111)
        $display("FAIL glitch4_early tick %0d: got rst_n=%b want 111", k, rst_n);
      else if (k == 7 && (rst_n !== 3'b000 || done !== 1'b0))
        $display("FAIL glitch4_assert: got rst_n=%b done=%b want 000 0", rst_n, done);
      else pass_cnt++;
    end
    waited = 0;
    while (done !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    total_cnt++;
    if (done !== 1'b1 || rst_n !== 3'b111)
      $display("FAIL glitch4_recover: got done=%b rst_n=%b want 1 111", done, rst_n);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [2:0] exp_rst;
    bypass = 1'b1;
    tick();
    xres_n = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();   // tick k is edge E+k-1
      if (k == 1) xres_n = 1'b1;
      exp_rst = (k >= 11) ? 3'b111 : (k >= 9) ? 3'b011 : (k >= 7) ? 3'b001 :
                (k >= 4) ? 3'b000 : 3'b111;
      total_cnt++;
      if (rst_n !== exp_rst || done !== (k <= 3 || k >= 11))
        $display("FAIL bypass tick %0d: got rst_n=%b done=%b want rst_n=%b done=%b",
                 k, rst_n, done, exp_rst, (k <= 3 || k >= 11));
      else pass_cnt++;
      if (k == 3) begin
        total_cnt++;
        if (filt !== 1'b0) $display("FAIL bypass_filt: got %b want 0", filt);
        else pass_cnt++;
      end
    end
    bypass = 1'b0;
    tick();
  endtask

`ifdef XRES_SW_RESET_EN
  task automatic test_sw_reset();
    logic [2:0] exp_rst;
    // Request held high straight through the ack: a second SWRST follows it.
    sw_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();   // tick 1 is the SWRST entry edge S
      if (k == 10) sw_req = 1'b0;
      exp_rst = (k == 10) ? 3'b001 : (k == 9) ? 3'b111 : (k >= 7) ? 3'b011 : 3'b001;
      total_cnt++;
      if (rst_n !== exp_rst || done !== (k == 9) || sw_ack !== (k == 9))
        $display("FAIL sw_reset tick %0d: got rst_n=%b done=%b ack=%b want rst_n=%b done=%b ack=%b",
                 k, rst_n, done, sw_ack, exp_rst, (k == 9), (k == 9));
      else pass_cnt++;
    end
    // Request dropped during the second SWRST; ack still arrives 8 edges after entry.
    for (int k = 11; k <= 19; k++) begin
      tick();
      total_cnt++;
      if (sw_ack !== (k == 18) || done !== (k >= 18))
        $display("FAIL sw_second tick %0d: got ack=%b done=%b want ack=%b done=%b",
                 k, sw_ack, done, (k == 18), (k >= 18));
      else pass_cnt++;
    end
  endtask

  task automatic test_sw_abort();
    int waited;
    logic ack_seen;
    bypass = 1'b1;
    sw_req = 1'b1;
    tick();   // S: SWRST entered
    sw_req = 1'b0;
    xres_n = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 2) xres_n = 1'b1;
      total_cnt++;
      if (k <= 4 && rst_n !== 3'b001)
        $display("FAIL sw_abort_early tick %0d: got rst_n=%b want 001", k, rst_n);
      else if (k == 5 && (rst_n !== 3'b000 || done !== 1'b0))
        $display("FAIL sw_abort_hold: got rst_n=%b done=%b want 000 0", rst_n, done);
      else pass_cnt++;
    end
    ack_seen = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 30) begin
      tick();
      ack_seen |= sw_ack;
      waited++;
    end
    repeat (3) begin
      tick();
      ack_seen |= sw_ack;
    end
    total_cnt++;
    if (done !== 1'b1 || ack_seen !== 1'b0)
      $display("FAIL sw_abort_recover: got done=%b ack_seen=%b want 1 0", done, ack_seen);
    else pass_cnt++;
    bypass = 1'b0;
  endtask
`endif

  task automatic test_mid_reset();
    logic [2:0] exp_rst;
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    repeat (11) tick();
    total_cnt++;
    if (rst_n !== 3'b011) $display("FAIL mid_reset_pre: got rst_n=%b want 011", rst_n);
    else pass_cnt++;
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    total_cnt++;
    if (rst_n !== 3'b000 || done !== 1'b0 || filt !== 1'b0)
      $display("FAIL mid_reset_clear: got rst_n=%b done=%b filt=%b want 000 0 0", rst_n, done, filt);
    else pass_cnt++;
    for (int e = 1; e <= 13; e++) begin
      tick();
      exp_rst = (e >= 13) ? 3'b111 : (e >= 11) ? 3'b011 : (e >= 9) ? 3'b001 : 3'b000;
      total_cnt++;
      if (rst_n !== exp_rst || done !== (e >= 13))
        $display("FAIL mid_reset_restart edge %0d: got rst_n=%b done=%b want rst_n=%b done=%b",
                 e, rst_n, done, exp_rst, (e >= 13));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch();
    test_bypass();
`ifdef XRES_SW_RESET_EN
    test_sw_reset();
    test_sw_abort();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
